rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Round-robin arbiter sharing the single register-file write port among up to NREQ write-back requesters (ALU, load unit, CSR unit, multiplier). It takes valid/ready requests, picks one winner per cycle, and drives a registered one-cycle write strobe into the register-file write port. Writes to x0 are accepted and discarded. The block sits between the execute/write-back units and the register file.

## Interface
- NREQ, 4, number of requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW]
- req_data  in  NREQ*XLEN  packed write data; requester i occupies bits [i*XLEN +: XLEN]
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- stall  in  1  when high, no request is granted
- rf_we  out  1  register-file write enable, one-cycle pulse
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  XLEN  register-file write data
- rr_ptr_o  out  clog2(NREQ)  current highest-priority index, for debug and verification

## Operation
- rr_ptr holds the highest-priority requester. Search order is rr_ptr, rr_ptr+1, … NREQ-1, 0, … rr_ptr-1.
- Grant: if stall=0 and any req_valid is set, req_ready is asserted for the first valid index in search order. Otherwise req_ready=0.
  - req_ready is combinational from req_valid, stall and rr_ptr.
  - Requesters hold valid, addr and data stable until they see ready.
- On a transfer by requester g:
  - rr_ptr <= (g+1) mod NREQ.
  - rf_waddr <= req_addr[g] and rf_wdata <= req_data[g].
  - rf_we <= (req_addr[g] != 0).
- Without a transfer: rf_we <= 0, and rf_waddr, rf_wdata and rr_ptr hold.
- x0 write: the requester is still granted and the pointer still advances, but rf_we stays 0.
- stall only blocks new grants. A write accepted in the previous cycle still pulses rf_we.
- Exactly one grant per cycle at most. Throughput is one write per cycle.

## Timing
- Reset values (asynchronous, while reset_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0.
  - req_ready=0 during reset. After release it is purely combinational from req_valid, stall and rr_ptr.
- Latency: transfer in cycle t gives rf_we=1 in cycle t+1 only. The register file captures the write at the end of t+1.
- Back-to-back transfers give a continuous rf_we with updated addr/data every cycle.
- Reset asserted mid-write clears rf_we immediately, and the pending write is lost.
- Pointer wrap: a grant to index NREQ-1 sets rr_ptr=0.
- A requester dropping valid without a grant is allowed and has no effect.
- A stall that rises in the same cycle as valid suppresses the grant that cycle.

## Structure
- Shared package rv32_pkg holds XLEN=32, REG_AW=5 and REG_ZERO=5'd0.
- Sub-module rr_picker (NREQ): inputs req, ptr; outputs one-hot gnt, binary gnt_idx, any.
  - Purely combinational, so it can be reused by a future memory-port arbiter.
- Top level contains the pointer register, output register stage and x0 filter.

## Test plan
- Single request: req_valid=4'b0100, addr=5'd7, data=32'hDEADBEEF.
  - Same cycle: req_ready=4'b0100.
  - Next cycle: rf_we=1, rf_waddr=7, rf_wdata=DEADBEEF, and rr_ptr=3.
- Fairness: all four requesters held valid for 8 cycles.
  - Grant order 0,1,2,3,0,1,2,3.
  - rf_we high for cycles 1..8; each requester written exactly twice.
- x0 drop: requester 1 writes addr 0, data 32'h1234.
  - req_ready[1]=1 and rr_ptr advances to 2.
  - rf_we stays 0 the next cycle.
- Stall: all valid, stall=1 for 3 cycles.
  - req_ready=0 throughout, rf_we=0, rr_ptr unchanged.
  - After stall drops, requester rr_ptr is granted first.
- Wrap and skip: rr_ptr=3, req_valid=4'b0010.
  - Requester 1 is granted and rr_ptr becomes 2.
  - Then req_valid=4'b1001: requester 3 is granted and rr_ptr becomes 0.
- Reset mid-operation: reset_n pulled low asynchronously in the cycle where rf_we=1.
  - rf_we, rf_waddr, rf_wdata and rr_ptr drop to 0 before the next clock edge.
  - The first grant after release goes to requester 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 register-file widths and constants
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector starting the search at ptr
module rr_picker #(
  parameter int NREQ = 4,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    // scan farthest-first so the nearest valid index in search order wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % NREQ] = 1'b1;
        gnt_idx = PW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the register-file write port with a registered strobe
module rf_write_arbiter
  import rv32_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XLEN = rv32_pkg::XLEN,
  parameter int AW = rv32_pkg::REG_AW,
  localparam int PW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 stall,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [PW-1:0]        rr_ptr_o
);
  logic [NREQ-1:0] req_eff, gnt;
  logic [PW-1:0]   gnt_idx, ptr_q, ptr_d;
  logic            any, rf_we_q, rf_we_d;
  logic [AW-1:0]   gnt_addr, waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  assign req_eff = stall ? '0 : req_valid;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req(req_eff),
    .ptr(ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .any(any)
  );

  assign req_ready = reset_n ? gnt : '0;

  always_comb begin
    gnt_addr = req_addr[gnt_idx*AW +: AW];
    // x0 writes are granted and consume a slot but never strobe the port
    rf_we_d = any && (gnt_addr != AW'(REG_ZERO));
    waddr_d = any ? gnt_addr : waddr_q;
    wdata_d = any ? req_data[gnt_idx*XLEN +: XLEN] : wdata_q;
    ptr_d = !any ? ptr_q : (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ptr_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ptr_q <= ptr_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign rr_ptr_o = ptr_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, hand sequences and random traffic against a reference model
module tb_rf_write_arbiter;
  logic         clk, reset_n, stall, rf_we;
  logic [3:0]   req_valid, req_ready;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [1:0]   rr_ptr_o;

  int n_chk = 0, n_fail = 0;
  int m_ptr;
  logic m_we;
  logic [4:0] m_waddr;
  logic [31:0] m_wdata;
  int cnt[4];

  typedef struct {
    logic [3:0] v;
    logic s;
    logic [4:0] a;
    logic [31:0] d;
    logic [3:0] er;
    logic [1:0] ep;
    logic ew;
  } vec_t;
  vec_t tab[11];

  rf_write_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rr_ptr_o(rr_ptr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic drive(input logic [3:0] v, input logic s, input logic [19:0] a, input logic [127:0] d);
    req_valid = v;
    stall = s;
    req_addr = a;
    req_data = d;
    #3;
  endtask

  task automatic step();
    int g;
    g = stall ? -1 : pick(req_valid, m_ptr);
    chk("req_ready", {28'd0, req_ready}, g < 0 ? 32'd0 : 32'd1 << g);
    chk("rr_ptr", {30'd0, rr_ptr_o}, 32'(m_ptr));
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("rf_wdata", rf_wdata, m_wdata);
    if (g >= 0) begin
      m_waddr = req_addr[g*5 +: 5];
      m_wdata = req_data[g*32 +: 32];
      m_we = (m_waddr != 5'd0);
      m_ptr = (g + 1) % 4;
    end else m_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tab[0]  = '{4'b0100, 1'b0, 5'd7,  32'hDEADBEEF, 4'b0100, 2'd0, 1'b0};
    tab[1]  = '{4'b0000, 1'b0, 5'd0,  32'h0,        4'b0000, 2'd3, 1'b1};
    tab[2]  = '{4'b0010, 1'b0, 5'd9,  32'h11110000, 4'b0010, 2'd3, 1'b0};
    tab[3]  = '{4'b1001, 1'b0, 5'd10, 32'h22220000, 4'b1000, 2'd2, 1'b1};
    tab[4]  = '{4'b0010, 1'b0, 5'd0,  32'h00001234, 4'b0010, 2'd0, 1'b1};
    tab[5]  = '{4'b0000, 1'b0, 5'd0,  32'h0,        4'b0000, 2'd2, 1'b0};
    tab[6]  = '{4'b1111, 1'b1, 5'd5,  32'h55550000, 4'b0000, 2'd2, 1'b0};
    tab[7]  = '{4'b1111, 1'b1, 5'd5,  32'h55550000, 4'b0000, 2'd2, 1'b0};
    tab[8]  = '{4'b1111, 1'b1, 5'd5,  32'h55550000, 4'b0000, 2'd2, 1'b0};
    tab[9]  = '{4'b1111, 1'b0, 5'd5,  32'h55550000, 4'b0100, 2'd2, 1'b0};
    tab[10] = '{4'b0000, 1'b0, 5'd0,  32'h0,        4'b0000, 2'd3, 1'b1};
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    reset_n = 1'b0;
    drive(4'hF, 1'b0, {4{5'd6}}, {4{32'hA5A5A5A5}});
    chk("reset_ready", {28'd0, req_ready}, 32'd0);
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_ptr", {30'd0, rr_ptr_o}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(tab[i].v, tab[i].s, {4{tab[i].a}}, {4{tab[i].d}});
      chk($sformatf("tab%0d_ready", i), {28'd0, req_ready}, {28'd0, tab[i].er});
      chk($sformatf("tab%0d_ptr", i), {30'd0, rr_ptr_o}, {30'd0, tab[i].ep});
      chk($sformatf("tab%0d_we", i), {31'd0, rf_we}, {31'd0, tab[i].ew});
      step();
    end
    // asynchronous reset while a write strobe is on the port
    drive(4'b0001, 1'b0, {4{5'd3}}, {4{32'hCAFE0000}});
    step();
    chk("pre_reset_we", {31'd0, rf_we}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_reset_we", {31'd0, rf_we}, 32'd0);
    chk("mid_reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("mid_reset_wdata", rf_wdata, 32'd0);
    chk("mid_reset_ptr", {30'd0, rr_ptr_o}, 32'd0);
    chk("mid_reset_ready", {28'd0, req_ready}, 32'd0);
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    // fairness: all four requesters held valid for eight cycles
    for (int k = 0; k < 9; k++) begin
      drive(k < 8 ? 4'hF : 4'h0, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1},
            {32'h44, 32'h33, 32'h22, 32'h11});
      if (k < 8) chk("fair_order", {28'd0, req_ready}, 32'd1 << (k % 4));
      if (k >= 1) begin
        chk("fair_we", {31'd0, rf_we}, 32'd1);
        if (rf_we === 1'b1 && rf_waddr >= 5'd1 && rf_waddr <= 5'd4) cnt[rf_waddr - 1]++;
      end
      step();
    end
    for (int i = 0; i < 4; i++) chk($sformatf("fair_count%0d", i), 32'(cnt[i]), 32'd2);
    for (int n = 0; n < 400; n++) begin
      logic [19:0] a;
      for (int i = 0; i < 4; i++) a[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive(4'($urandom), $urandom_range(0, 3) == 0, a,
            {$urandom, $urandom, $urandom, $urandom});
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
